// File: rtl/bcd_to_binary_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq_if
// Handshake bundle for the sequential BCD-to-binary converter.
//   in_valid / in_ready / bcd_in : word input channel (source -> converter)
//   out_valid / out_ready        : result channel handshake
//   bin_out / err_out            : converted value and invalid-digit flag
// modport master : the side that supplies words and consumes results
// modport slave  : the converter itself
// DIGITS and BIN_W must match the parameters of the converter instance.
// ---------------------------------------------------------------------------
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err_out;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err_out
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err_out
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
// Converts a DIGITS-digit packed BCD word to binary, one digit per clock,
// most-significant digit first (acc = acc*10 + digit). Any digit above 9 is
// treated as 0 and raises a per-word error flag.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bcd_to_binary_seq_if
//            in_valid/in_ready/bcd_in, out_valid/out_ready/bin_out/err_out
//
// Parameters:
//   DIGITS : BCD digits per word, 1..9
//   BIN_W  : result width, at least ceil(log2(10^DIGITS))
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a word; in_ready high
// BUSY  | folding one digit per clock into the accumulator
// DONE  | result presented on bin_out/err_out; out_valid high until taken
// ---------------------------------------------------------------------------
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_to_binary_seq_if.slave   bus
);

    localparam int WORD_W = 4 * DIGITS;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PROD_W = BIN_W + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [WORD_W-1:0]   shift_q,   shift_d;
    logic [BIN_W-1:0]    acc_q,     acc_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                err_q,     err_d;
    logic [BIN_W-1:0]    bin_q,     bin_d;
    logic                err_out_q, err_out_d;

    logic [3:0]          digit_raw;
    logic                digit_bad;
    logic [3:0]          digit;
    logic [PROD_W-1:0]   prod;
    logic [BIN_W-1:0]    acc_next;
    logic                err_next;
    logic                last_digit;
    logic                unused_prod_hi;

    // Datapath for the digit currently at the top of the shift register.
    // An invalid code contributes 0, matching the single-digit converter.
    assign digit_raw  = shift_q[WORD_W-1 -: 4];
    assign digit_bad  = (digit_raw > 4'd9);
    assign digit      = digit_bad ? 4'd0 : digit_raw;

    // Widened product so the *10 cannot lose bits before the deliberate
    // truncation back to BIN_W (results wrap if BIN_W is undersized).
    assign prod       = ({4'b0000, acc_q} * PROD_W'(10)) + PROD_W'(digit);
    assign acc_next   = prod[BIN_W-1:0];
    assign err_next   = err_q | digit_bad;
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    assign unused_prod_hi = ^prod[PROD_W-1:BIN_W];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        bin_d     = bin_q;
        err_out_d = err_out_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_d = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                acc_d   = acc_next;
                err_d   = err_next;
                shift_d = shift_q << 4;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    bin_d     = acc_next;
                    err_out_d = err_next;
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bin_q     <= '0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            bin_q     <= bin_d;
            err_out_q <= err_out_d;
        end
    end

    // Handshake outputs decode straight from the state register, so reset
    // forces in_ready high and out_valid low without waiting for a clock.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bin_out   = bin_q;
    assign bus.err_out   = err_out_q;

endmodule
